// File: rtl/uart_tx_drain.sv
// Purpose : UART transmitter that drains a first-word-fall-through FIFO, one frame per word.
// Latency : pop in IDLE cycle T, start bit on tx from T+1; frames are back-to-back with one IDLE cycle between.
// Backpres: pops only in IDLE when the FIFO is non-empty; fifo_empty is ignored while a frame is in flight.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   fifo_dout/empty     - FIFO head word and empty flag (FWFT read port)
//   fifo_rd_en          - one-cycle pop strobe (combinational decode of IDLE && !empty && !rst)
//   tx                  - serial line, idle high (registered)
//   busy                - frame in progress (registered)
//   tx_done             - one-cycle pulse on the last cycle of the final stop bit (registered)
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_drain #(
  parameter int DWIDTH       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  // Counter sized for the longest state (two stop bits).
  localparam int CW = $clog2(CLKS_PER_BIT * 2);
  localparam int BW = $clog2(DWIDTH + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  // tx_done is registered, so it is loaded one cycle ahead of the final stop cycle.
  localparam logic [CW-1:0] STOP_PRE  = CW'(STOP_BITS * CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DWIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [BW-1:0]     bit_idx_q;
  logic [BW-1:0]     bit_idx_d;
  logic [DWIDTH-1:0] shift_q;
  logic [DWIDTH-1:0] shift_d;
  logic              tx_q;
  logic              busy_q;
  logic              tx_done_q;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  assign cnt_d     = cnt_q + CW'(1);
  assign bit_idx_d = bit_idx_q + BW'(1);
  assign shift_d   = shift_q >> 1;
  assign bit_end   = (cnt_q == BIT_LAST);

  // Pop is decoded combinationally so the FIFO advances in the same cycle the word is latched.
  assign fifo_rd_en = (state_q == S_IDLE) && !fifo_empty && !rst;

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

  // tx_q always carries the level for the state being entered, so tx is glitch-free and registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q   <= fifo_dout;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^fifo_dout;
`endif
            state_q   <= S_START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end
        end

        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == DATA_LAST) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= S_PARITY;
              tx_q      <= parity_q;
`else
              state_q   <= S_STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              shift_q   <= shift_d;
              tx_q      <= shift_d[0];
              bit_idx_q <= bit_idx_d;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif

        S_STOP: begin
          tx_q <= 1'b1;
          if (cnt_q == STOP_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_q == STOP_PRE) begin
              tx_done_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          bit_idx_q <= '0;
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: FIFO modelled as a queue, frames predicted from the serial framing rules.
// Checks at the falling edge; inputs change 1 time unit after the rising edge.
// Mirrors the parity build option through UART_TX_PARITY_EN.
module tb_uart_tx_drain;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = (1 + DW + P + SB) * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          tx_done;

  logic [DW-1:0] q[$];
  int            n_err  = 0;
  int            n_chk  = 0;
  int            cyc    = 0;
  int            n_pops = 0;

  uart_tx_drain #(
    .DWIDTH      (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() != 0) ? q[0] : '0;
  endtask

  // One clock: the FIFO model pops on the edge where the strobe was seen high.
  task automatic step();
    logic rd;
    rd = fifo_rd_en;
    @(posedge clk);
    if (rd && q.size() > 0) begin
      void'(q.pop_front());
      n_pops++;
    end
    cyc++;
    #1 drive();
    @(negedge clk);
  endtask

  // Expected line level k cycles into a frame: start, data LSB first, [even parity], stop.
  function automatic logic exp_bit(input logic [DW-1:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return b[slot-1];
    if (P == 1 && slot == DW + 1) return ^b;
    return 1'b1;
  endfunction

  // Entered at the falling edge of the pop cycle. Optionally pushes a word or asserts reset mid-frame.
  task automatic run_frame(input logic [DW-1:0] b, input int push_k, input logic [DW-1:0] push_v,
                           input int abort_k);
    check("pop_rd_en", fifo_rd_en, 1);
    check("pop_tx_idle", tx, 1);
    check("pop_busy_low", busy, 0);
    step();
    for (int k = 0; k < L; k++) begin
      if (k == push_k) begin
        q.push_back(push_v);
        drive();
        #1;
      end
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        check("abort_rd_en", fifo_rd_en, 0);
        step();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
        #1;
        return;
      end
      check("tx_bit", tx, exp_bit(b, k));
      check("busy", busy, 1);
      check("tx_done", tx_done, (k == L - 1));
      check("rd_en_in_frame", fifo_rd_en, 0);
      step();
    end
    check("post_busy", busy, 0);
    check("post_tx", tx, 1);
  endtask

  task automatic wait_pop(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fifo_rd_en) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    check("pop_timeout", fifo_rd_en, 1);
  endtask

  // Sends everything queued; consecutive pops must be exactly one frame plus one IDLE cycle apart.
  task automatic drain();
    bit ok;
    int prev;
    logic [DW-1:0] b;
    prev = -1;
    while (q.size() > 0) begin
      wait_pop(4, ok);
      if (!ok) return;
      if (prev >= 0) check("frame_period", cyc - prev, L + 1);
      prev = cyc;
      b = q[0];
      run_frame(b, -1, '0, -1);
      if (q.size() > 0) check("b2b_pop", fifo_rd_en, 1);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_tx", tx, 1);
      check("idle_busy", busy, 0);
      check("idle_rd_en", fifo_rd_en, 0);
      check("idle_done", tx_done, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int pops0;
    logic [DW-1:0] v;

    // Reset held with the FIFO non-empty: no pops, line idle.
    rst = 1'b1;
    q.push_back(8'hA5);
    drive();
    for (int i = 0; i < 10; i++) begin
      step();
      check("rsthold_tx", tx, 1);
      check("rsthold_busy", busy, 0);
      check("rsthold_rd_en", fifo_rd_en, 0);
      check("rsthold_done", tx_done, 0);
    end

    // Single byte 0xA5 right out of reset.
    rst = 1'b0;
    #1;
    pops0 = n_pops;
    drain();
    idle_cycles(5);
    check("single_pop_count", n_pops - pops0, 1);

    // Four 16-bit writes {~i,i} read back low byte first.
    for (int i = 0; i < 4; i++) begin
      v = DW'(i);
      q.push_back(v);
      q.push_back(~v);
    end
    drive();
    #1;
    pops0 = n_pops;
    drain();
    idle_cycles(6);
    check("preload_pop_count", n_pops - pops0, 8);

    // FIFO goes non-empty mid-frame: no extra pop until the frame ends.
    q.push_back(8'h3C);
    drive();
    #1;
    pops0 = n_pops;
    wait_pop(4, ok);
    if (ok) begin
      run_frame(8'h3C, L / 2, 8'hC3, -1);
      check("late_push_b2b", fifo_rd_en, 1);
      drain();
    end
    idle_cycles(3);
    check("late_push_pops", n_pops - pops0, 2);

    // Reset in data bit 3: popped byte is lost, next frame carries the following byte.
    q.push_back(8'h11);
    q.push_back(8'h22);
    q.push_back(8'h33);
    drive();
    #1;
    pops0 = n_pops;
    wait_pop(4, ok);
    if (ok) begin
      run_frame(8'h11, -1, '0, CPB * 4 + 1);
      check("after_rst_pop", fifo_rd_en, 1);
      drain();
    end
    idle_cycles(3);
    check("rst_test_pops", n_pops - pops0, 3);

    // Parity vectors (ordinary data in the default build).
    q.push_back(8'h07);
    q.push_back(8'h03);
    drive();
    #1;
    drain();
    idle_cycles(2);

    // Random bursts separated by random idle gaps.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) q.push_back(DW'($urandom));
      drive();
      #1;
      pops0 = n_pops;
      drain();
      idle_cycles($urandom_range(1, 5));
      check("rand_pop_count", n_pops - pops0, n);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
